// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the division controller.
//   state_t      - controller FSM states
//   FINAL_W_DEF  - default divider terminal-value width
//   CNT_W_DEF    - default output-pulse counter width
package div_pkg;

   localparam int unsigned FINAL_W_DEF = 10;
   localparam int unsigned CNT_W_DEF   = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/division_ctrl_if.sv
// division_ctrl_if: job-request and divider-side signals of the division controller.
//   Job side     : req, final_in, cycles_in, abort (to ctrl); ack, err, busy, done, aborted,
//                  pulse_cnt (from ctrl)
//   Divider side : div_out (to ctrl); div_start, div_final (from ctrl)
//   master modport drives the requests and the divider output; slave is the controller.
interface division_ctrl_if
   import div_pkg::*;
#(
   parameter int unsigned FINAL_W = FINAL_W_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF
);

   logic               req;
   logic [FINAL_W-1:0] final_in;
   logic [CNT_W-1:0]   cycles_in;
   logic               abort;
   logic               div_out;
   logic               div_start;
   logic [FINAL_W-1:0] div_final;
   logic               ack;
   logic               err;
   logic               busy;
   logic               done;
   logic               aborted;
   logic [CNT_W-1:0]   pulse_cnt;

   modport master (
      output req, final_in, cycles_in, abort, div_out,
      input  div_start, div_final, ack, err, busy, done, aborted, pulse_cnt
   );

   modport slave (
      input  req, final_in, cycles_in, abort, div_out,
      output div_start, div_final, ack, err, busy, done, aborted, pulse_cnt
   );

endinterface

// File: rtl/edge_rise.sv
// edge_rise: rising-edge detector with a one-cycle registered history.
//   clk   - clock
//   reset - synchronous active-high reset (clears the history)
//   d     - sampled input
//   rise  - d & ~d_q, high in the cycle d is first seen high
module edge_rise (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);

   logic d_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         d_q <= 1'b0;
      end else begin
         d_q <= d;
      end
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/division_ctrl.sv
// division_ctrl: accepts a job (terminal value + pulse count), starts the clock divider,
// counts divided-clock rising edges and reports completion, rejection or abort.
//   clk   - clock
//   reset - synchronous active-high reset
//   bus   - division_ctrl_if slave: job request/response and divider control
// All outputs are registered.
module division_ctrl
   import div_pkg::*;
#(
   parameter int unsigned FINAL_W = FINAL_W_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic           clk,
   input  logic           reset,
   division_ctrl_if.slave bus
);

   state_t             state_q, state_d;
   logic [FINAL_W-1:0] final_q, final_d;
   logic [CNT_W-1:0]   cycles_q, cycles_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               start_q, start_d;
   logic               ack_q, ack_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               aborted_q, aborted_d;
   logic               rise;
   logic               job_ok;
   logic               terminal;

   edge_rise u_edge_rise (
      .clk   (clk),
      .reset (reset),
      .d     (bus.div_out),
      .rise  (rise)
   );

   always_comb begin
      state_d   = state_q;
      final_d   = final_q;
      cycles_d  = cycles_q;
      cnt_d     = cnt_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      job_ok    = (bus.final_in != '0) && (bus.cycles_in != '0);
      // Stopping at cycles-1 means the counter tops out at cycles and can never wrap.
      terminal  = rise && (cnt_q == (cycles_q - CNT_W'(1)));

      case (state_q)
         IDLE: begin
            if (bus.req) begin
               if (job_ok) begin
                  final_d  = bus.final_in;
                  cycles_d = bus.cycles_in;
                  cnt_d    = '0;
                  ack_d    = 1'b1;
                  state_d  = LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LOAD: begin
            state_d = RUN;
         end
         RUN: begin
            if (rise) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            // abort wins over a coincident terminal edge
            if (bus.abort) begin
               aborted_d = 1'b1;
               state_d   = IDLE;
            end else if (terminal) begin
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Start lags RUN entry by one cycle but drops in the same cycle RUN is left.
      start_d = (state_q == RUN) && (state_d == RUN);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         final_q   <= '0;
         cycles_q  <= '0;
         cnt_q     <= '0;
         start_q   <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         final_q   <= final_d;
         cycles_q  <= cycles_d;
         cnt_q     <= cnt_d;
         start_q   <= start_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   assign bus.div_start = start_q;
   assign bus.div_final = final_q;
   assign bus.ack       = ack_q;
   assign bus.err       = err_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.aborted   = aborted_q;
   assign bus.pulse_cnt = cnt_q;

endmodule

// File: tb/tb_division_ctrl.sv
// tb_division_ctrl: directed job scenarios followed by randomized traffic, every cycle
// compared against a job-level reference model.
module tb_division_ctrl;

   localparam int unsigned FW = 10;
   localparam int unsigned CW = 8;

   logic clk;
   logic reset;

   division_ctrl_if #(.FINAL_W(FW), .CNT_W(CW)) bus ();

   division_ctrl #(.FINAL_W(FW), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a job is pending from acceptance until it completes, aborts or is reset.
   bit          job_open;     // accepted and not yet finished
   bit          job_loading;  // the cycle right after acceptance
   bit          job_closing;  // the single completion cycle
   bit          prev_dout;
   int          edges;
   int          target;
   logic [FW-1:0] e_final;
   bit          e_ack, e_err, e_busy, e_done, e_aborted, e_start;

   task automatic model_step(input bit r, input logic [FW-1:0] f, input logic [CW-1:0] c,
                             input bit a, input bit d, input bit rst);
      bit rising;
      rising    = d && !prev_dout;
      prev_dout = rst ? 1'b0 : d;
      e_ack = 0; e_err = 0; e_done = 0; e_aborted = 0; e_start = 0;
      if (rst) begin
         job_open = 0; job_loading = 0; job_closing = 0;
         edges = 0; target = 0; e_final = '0; e_busy = 0;
         return;
      end
      if (job_closing) begin
         job_closing = 0;
      end else if (!job_open) begin
         if (r) begin
            if (f != 0 && c != 0) begin
               job_open = 1; job_loading = 1;
               e_final = f; target = int'(c); edges = 0; e_ack = 1;
            end else begin
               e_err = 1;
            end
         end
      end else if (job_loading) begin
         job_loading = 0;
      end else begin
         if (rising) edges++;
         if (a) begin
            e_aborted = 1; job_open = 0;
         end else if (rising && edges == target) begin
            e_done = 1; job_open = 0; job_closing = 1;
         end else begin
            e_start = 1;
         end
      end
      e_busy = job_open || job_closing;
   endtask

   task automatic step(input bit r, input int f, input int c, input bit a, input bit d,
                       input bit rst);
      logic [FW-1:0] fv;
      logic [CW-1:0] cv;
      fv = FW'(f);
      cv = CW'(c);
      reset        = rst;
      bus.req      = r;
      bus.final_in = fv;
      bus.cycles_in = cv;
      bus.abort    = a;
      bus.div_out  = d;
      model_step(r, fv, cv, a, d, rst);
      @(posedge clk);
      #1;
      check("ack",       32'(bus.ack),       32'(e_ack));
      check("err",       32'(bus.err),       32'(e_err));
      check("busy",      32'(bus.busy),      32'(e_busy));
      check("done",      32'(bus.done),      32'(e_done));
      check("aborted",   32'(bus.aborted),   32'(e_aborted));
      check("div_start", 32'(bus.div_start), 32'(e_start));
      check("div_final", 32'(bus.div_final), 32'(e_final));
      check("pulse_cnt", 32'(bus.pulse_cnt), 32'(edges));
   endtask

   // Toggle div_out every cycle for n cycles (one rising edge per two cycles).
   task automatic toggle(input int n, input bit r, input int f, input int c);
      for (int i = 0; i < n; i++) step(r, f, c, 1'b0, (i % 2) == 1, 1'b0);
   endtask

   initial begin
      bus.req = 0; bus.final_in = '0; bus.cycles_in = '0; bus.abort = 0; bus.div_out = 0;
      reset = 1;

      // Reset state
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);

      // Accept and run: final 4, 3 cycles
      step(1, 4, 3, 0, 0, 0);
      check("s1_ack", 32'(bus.ack), 32'd1);
      step(0, 4, 3, 0, 0, 0);
      step(0, 4, 3, 0, 0, 0);
      check("s1_start", 32'(bus.div_start), 32'd1);
      toggle(6, 0, 0, 0);
      check("s1_done", 32'(bus.done), 32'd1);
      check("s1_cnt", 32'(bus.pulse_cnt), 32'd3);
      check("s1_start_off", 32'(bus.div_start), 32'd0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Rejects
      step(1, 0, 5, 0, 0, 0);
      check("s2_err_a", 32'(bus.err), 32'd1);
      step(0, 0, 0, 0, 0, 0);
      step(1, 7, 0, 0, 0, 0);
      check("s2_err_b", 32'(bus.err), 32'd1);
      step(0, 0, 0, 0, 0, 0);

      // Abort after 4 edges
      step(1, 2, 10, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      toggle(8, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      check("s3_aborted", 32'(bus.aborted), 32'd1);
      check("s3_cnt", 32'(bus.pulse_cnt), 32'd4);
      step(0, 0, 0, 0, 0, 0);

      // Abort coincident with terminal edge
      step(1, 3, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1, 0);
      check("s4_aborted", 32'(bus.aborted), 32'd1);
      check("s4_done", 32'(bus.done), 32'd0);
      step(0, 0, 0, 0, 0, 0);

      // Reset mid-run after 2 edges, then a fresh job
      step(1, 5, 9, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      toggle(4, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      check("s5_busy", 32'(bus.busy), 32'd0);
      step(1, 6, 2, 0, 0, 0);
      check("s5_ack", 32'(bus.ack), 32'd1);
      toggle(8, 0, 0, 0);

      // Back-to-back: req held for the whole first job and through DONE
      step(1, 9, 1, 0, 0, 0);
      toggle(6, 1, 9, 1);
      step(0, 0, 0, 0, 0, 0);
      toggle(8, 0, 0, 0);

      // Longest job
      step(1, 1, 255, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      toggle(514, 0, 0, 0);
      check("s7_cnt", 32'(bus.pulse_cnt), 32'd255);
      step(0, 0, 0, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         int f;
         int c;
         f = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1023));
         c = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
         step($urandom_range(0, 3) == 0, f, c, $urandom_range(0, 39) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/division_ctrl.md
DIVISION_CTRL -- requirements
Module: division_ctrl

Interface
REQ-001 Parameter FINAL_W, default 10, SHALL set the divider terminal-value width.
REQ-002 Parameter CNT_W, default 8, SHALL set the output-pulse counter width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-005 req  in  1  SHALL carry the job request, level, held until ack.
REQ-006 final_in  in  FINAL_W  SHALL carry the divider terminal value for the job.
REQ-007 cycles_in  in  CNT_W  SHALL carry the number of divided-clock rising edges to run.
REQ-008 abort  in  1  SHALL cancel a running job.
REQ-009 div_out  in  1  SHALL carry count_out from the divider.
REQ-010 div_start  out  1  SHALL drive the divider start, as a level enable.
REQ-011 div_final  out  FINAL_W  SHALL drive the divider final value.
REQ-012 ack  out  1  SHALL be a one-cycle job-accept pulse.
REQ-013 err  out  1  SHALL be a one-cycle job-reject pulse.
REQ-014 busy  out  1  SHALL be high in every state except IDLE.
REQ-015 done  out  1  SHALL be a one-cycle completion pulse.
REQ-016 aborted  out  1  SHALL be a one-cycle abort pulse.
REQ-017 pulse_cnt  out  CNT_W  SHALL give the rising edges counted in the current job.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, LOAD, RUN and DONE; all outputs SHALL be registered.
REQ-019 In IDLE, req=1 with final_in!=0 and cycles_in!=0 SHALL latch both values, pulse ack in the next cycle, and go to LOAD.
REQ-020 In IDLE, req=1 with final_in=0 or cycles_in=0 SHALL pulse err in the next cycle, latch nothing, and stay in IDLE.
REQ-021 req SHALL be ignored outside IDLE; no ack or err is issued there.
REQ-022 LOAD SHALL last exactly one cycle, with div_final driven from the latched value, div_start=0 and pulse_cnt cleared to 0; the FSM then goes to RUN.
REQ-023 div_final SHALL hold the latched value from LOAD until the next accepted job.
REQ-024 In RUN, div_start SHALL be 1.
REQ-025 A rising edge of div_out SHALL be detected with a one-cycle registered history (div_out & ~div_out_q); each detected edge SHALL increment pulse_cnt by 1.
REQ-026 When an edge is detected with pulse_cnt == latched cycles-1, the FSM SHALL go to DONE, and pulse_cnt SHALL equal cycles.
REQ-027 pulse_cnt SHALL never wrap; cycles=2^CNT_W-1 is the maximum job length.
REQ-028 In DONE, div_start SHALL be 0 and done SHALL be 1 for exactly one cycle; the FSM then goes to IDLE and pulse_cnt holds its value.
REQ-029 abort=1 in RUN SHALL move the FSM to IDLE in the next cycle, drop div_start, pulse aborted, and suppress done.
REQ-030 abort SHALL have priority over a simultaneous terminal edge.
REQ-031 abort SHALL be ignored in IDLE, LOAD and DONE.
REQ-032 Latency SHALL be: req sampled to ack, 1 cycle; ack to div_start=1, 2 cycles; terminal edge to done, 1 cycle.
REQ-033 div_out edges outside RUN SHALL NOT change pulse_cnt, but SHALL still update div_out_q.

Reset
REQ-034 reset=1 SHALL, on the next clock edge and from any state, force the following values:
- FSM = IDLE
- div_start, ack, err, done, aborted, busy = 0
- div_final, pulse_cnt, latched final and cycles = 0
- div_out_q = 0
REQ-035 A reset during RUN SHALL terminate the job without a done or aborted pulse.

Structure
REQ-036 A shared package div_pkg SHALL hold the state enumeration (IDLE, LOAD, RUN, DONE) and the constants FINAL_W_DEF=10 and CNT_W_DEF=8.
REQ-037 The rising-edge detector SHALL be a sub-module named edge_rise (ports: clk, reset, d, rise).
REQ-038 The FSM and counter SHALL reside in division_ctrl.

Verification
REQ-039 Accept and run: final_in=4, cycles_in=3, req held.
- ack one cycle later; div_start high 2 cycles after ack.
- After 3 div_out rising edges: done one cycle after the 3rd edge, pulse_cnt=3, div_start=0.
REQ-040 Reject: req with final_in=0, cycles_in=5 -> err one cycle, busy stays 0; same with final_in=7, cycles_in=0.
REQ-041 Abort: job with final_in=2, cycles_in=10, abort after 4 edges -> aborted pulse, pulse_cnt=4, no done, IDLE next cycle.
REQ-042 Simultaneous events: abort coincident with the terminal edge (cycles_in=1) -> aborted only, done stays 0.
REQ-043 Reset mid-run: reset asserted in RUN after 2 edges -> all outputs 0 next cycle; a new req then gets ack normally.
REQ-044 Back-to-back jobs and busy-req: second req held through DONE -> ack in the cycle after IDLE is reentered; req asserted during RUN -> no ack.
